alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised execute unit and the next generation of the core's combinational ALU. It keeps the 4-bit opcode map and adds the following:
- ready/valid handshakes on both sides;
- an internal NZCV flag register;
- correct adc/sbc carry semantics and a true rotate;
- an iterative multiply and unsigned divide.

It sits between decode/register-read and writeback, and stalls issue through `in_ready` while an iterative op runs.

## Interface
- `WIDTH`, 16: datapath width. Must be ≥ 4 and a power of two.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: unit can accept an operation.
- `op` input 4: opcode.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `out_valid` output 1: `result`/`cc` valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output WIDTH: registered result.
- `cc` output 4: flag register {N,Z,C,V}.
- `cc_wr` input 1: direct flag-register write (flag restore).
- `cc_wdata` input 4: value for `cc_wr`.

## Operation
- Accept = `in_valid && in_ready`. Handoff = `out_valid && out_ready`.
- Opcodes:
  - 0 mov: a+b, flags unchanged.
  - 1 add: a+b, NZCV.
  - 2 adc: a+b+C, NZCV.
  - 3 sub: a-b, NZCV.
  - 4 sbc: a-b-!C, NZCV.
  - 5 and, 6 or, 7 xor: NZ.
  - 8 lsl, 9 lsr, 10 asr, 11 ror: NZ; the amount is `b[SHW-1:0]`; ror rotates right, and an amount of 0 returns a.
  - 12 ldr, 13 str: a+b, flags unchanged.
  - 14 mul: low WIDTH bits of a*b, NZ.
  - 15 divu: a/b unsigned, NZ; V=1 only if b==0, in which case result is all-ones.
- Add-type ops:
  - Computed as one (WIDTH+1)-bit sum.
  - Subtract uses a + ~b + cin, with cin=1 for sub and cin=C for sbc.
  - C = bit WIDTH of that sum (for subtract, C=1 means no borrow).
  - V = operands' signs equal (after inverting b for subtract) and result sign differs.
- N = result[WIDTH-1]; Z = (result == 0).
- The adc/sbc carry-in is the `cc` value at the accept cycle.
- FSM:
  - IDLE:
    - `in_ready`=1.
    - On accept of op 0–13, compute, load `result`/`cc`, go to DONE.
    - On accept of op 14/15, latch operands, clear the iteration counter, go to BUSY.
  - BUSY:
    - One iteration per cycle: shift-add for mul, restoring subtract for divu.
    - After WIDTH iterations, load `result`/`cc` and go to DONE.
    - divu with b==0 skips the iterations and goes to DONE the next cycle.
  - DONE: `out_valid`=1; on handshake, go to IDLE.
- `result` and `cc` hold their values in DONE until the handshake; no new op is accepted in BUSY or DONE.
- `cc_wr`:
  - Writes `cc` in any state.
  - If it coincides with the flag load of a completing op, `cc_wr` wins.
  - A `cc_wr` in the same cycle as an adc/sbc accept does not affect that op's carry-in, which uses the old C.
- Inputs are don't-care when `in_valid`=0. Operands are sampled only on accept.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `cc`=4'b0000.
- Reset in BUSY or DONE aborts the operation, and the result is discarded.
- Ops 0–13: accept in cycle T, `out_valid`=1 in T+1.
- mul / divu: accept in T, `out_valid`=1 in T+WIDTH+1.
- divu with b==0: accept in T, `out_valid`=1 in T+2.
- Throughput (single-cycle ops with `out_ready` tied high): one op every 2 cycles, because `in_ready` is registered-state based only, with no combinational path from `out_ready`.
- `result` and `cc` are registered outputs with no combinational input-to-output paths.

## Structure
- Package `alu_pkg` holds:
  - `alu_op_t` enum (16 opcodes).
  - CC bit-index localparams: N=3, Z=2, C=1, V=0.
  - `alu_state_t` {IDLE, BUSY, DONE}.
- Sub-module `alu_muldiv`:
  - Iterative WIDTH-cycle engine with `start`, `is_div`, `a`, `b`, `done`, `q`.
  - Owns the counter and partial-product/remainder registers.
  - Top level owns the FSM, the single-cycle datapath, flags and the handshake.

## Test plan
- Reset, then adc with `cc`=0010, a=16'hFFFF, b=0 → result 0000, `cc`=0110, `out_valid` at T+1.
- sub with a=0x8000, b=0x0001 → result 7FFF, `cc`=0011 (C=1 no borrow, V=1); then sbc with a=5, b=3 → result 2.
- ror with a=0x0001, b=1 → 0x8000, N=1; ror by 0 → a unchanged; lsl with b=0x0011 uses amount 1 → 0x0002.
- mul with a=300, b=300 → 0x5F90 at exactly T+17; in_ready=0 throughout; `out_ready` held low for 3 cycles keeps result and flags stable.
- divu 1000/7 → 142 at T+17; divu 5/0 → FFFF with V=1 at T+2.
- `rst` asserted mid-mul → next cycle `out_valid`=0, `in_ready`=1, `cc`=0; `cc_wr` with 1010 coinciding with a completing and → `cc`=1010.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, FSM states and flag bit positions shared by alu_mc
package alu_pkg;
  typedef enum logic [3:0] {
    OP_MOV, OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_XOR,
    OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_LDR, OP_STR, OP_MUL, OP_DIVU
  } alu_op_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;
  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_C = 1;
  localparam int CC_V = 0;
  function automatic logic is_iter(input alu_op_t o);
    return o == OP_MUL || o == OP_DIVU;
  endfunction
endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: WIDTH-cycle shift-add multiplier / restoring unsigned divider
module alu_muldiv #(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] q
);
  logic run, div;
  logic [SHW-1:0] cnt;
  logic [WIDTH-1:0] r, x, y, r_n, y_n;
  logic [WIDTH:0] sh, diff;
  // r: accumulator / remainder, x: multiplicand / divisor, y: multiplier / dividend-quotient
  always_comb begin
    sh = {r, y[WIDTH-1]};
    diff = sh - {1'b0, x};
    r_n = div ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : (y[0] ? r + x : r);
    y_n = div ? {y[WIDTH-2:0], ~diff[WIDTH]} : y >> 1;
  end
  assign done = run && &cnt;
  assign q = div ? y_n : r_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
      div <= is_div;
      cnt <= '0;
      r <= '0;
      x <= b;
      y <= a;
    end else if (run) begin
      run <= !done;
      cnt <= cnt + 1'b1;
      r <= r_n;
      y <= y_n;
      x <= div ? x : x << 1;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute unit with ready/valid handshakes and NZCV flags
module alu_mc import alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       cc,
  input  logic             cc_wr,
  input  logic [3:0]       cc_wdata
);
  alu_state_t state;
  alu_op_t opc;
  logic sub_t, cin, v, accept, start, md_done, mdiv, dz;
  logic [WIDTH-1:0] bb, res, q;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] rr;
  logic [3:0] cc_n;
  assign opc = alu_op_t'(op);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  // a zero divisor never starts the engine; the FSM supplies the all-ones result itself
  assign start = accept && is_iter(opc) && !(opc == OP_DIVU && b == '0);
  always_comb begin
    sub_t = opc == OP_SUB || opc == OP_SBC;
    cin = opc == OP_SUB || ((opc == OP_ADC || opc == OP_SBC) && cc[CC_C]);
    bb = sub_t ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
    rr = {a, a} >> b[SHW-1:0];
    case (opc)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_LSL:  res = a << b[SHW-1:0];
      OP_LSR:  res = a >> b[SHW-1:0];
      OP_ASR:  res = $unsigned($signed(a) >>> b[SHW-1:0]);
      OP_ROR:  res = rr[WIDTH-1:0];
      default: res = sum[WIDTH-1:0];
    endcase
    v = (a[WIDTH-1] == bb[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
    cc_n = opc inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC} ? {res[WIDTH-1], res == '0, sum[WIDTH], v} :
           opc inside {[OP_AND:OP_ROR]} ? {res[WIDTH-1], res == '0, cc[CC_C], cc[CC_V]} : cc;
  end
  alu_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk(clk), .rst(rst), .start(start), .is_div(opc == OP_DIVU),
    .a(a), .b(b), .done(md_done), .q(q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      result <= '0;
      cc <= '0;
      mdiv <= 1'b0;
      dz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mdiv <= opc == OP_DIVU;
          dz <= opc == OP_DIVU && b == '0;
          state <= is_iter(opc) ? BUSY : DONE;
          if (!is_iter(opc)) begin
            result <= res;
            cc <= cc_n;
          end
        end
        BUSY: if (dz || md_done) begin
          state <= DONE;
          result <= dz ? '1 : q;
          cc <= {dz || q[WIDTH-1], !dz && q == '0, cc[CC_C], mdiv ? dz : cc[CC_V]};
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (cc_wr) cc <= cc_wdata;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed scoreboard bench for alu_mc with per-op latency and flag checks
module tb_alu_mc;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, cc_wr = 0;
  logic in_ready, out_valid;
  logic [3:0] op = 0, cc, cc_wdata = 0;
  logic [15:0] a = 0, b = 0, result;
  int errors = 0, checks = 0;
  typedef struct packed {logic [15:0] res; logic [3:0] cc; logic [7:0] lat;} exp_t;
  exp_t sb[$];
  logic [3:0] mcc;

  alu_mc #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cc(cc),
    .cc_wr(cc_wr), .cc_wdata(cc_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one op from a negedge, wait for out_valid, hold out_ready low for 'hold' cycles, hand off
  task automatic issue(input string tag, input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] er, input logic [3:0] ec, input int el, input int hold);
    exp_t e;
    int n;
    logic busy_ok;
    logic [15:0] r0;
    logic [3:0] c0;
    sb.push_back('{res: er, cc: ec, lat: 8'(el)});
    op = o; a = x; b = y; in_valid = 1;
    n = 0;
    busy_ok = 1;
    do begin
      @(negedge clk);
      n++;
      in_valid = 0;
      cc_wr = 0;
      if (!out_valid && in_ready) busy_ok = 0;
    end while (!out_valid && n < 100);
    e = sb.pop_front();
    check({tag, " latency"}, n, e.lat);
    check({tag, " in_ready low while busy"}, busy_ok, 1);
    check({tag, " result"}, result, e.res);
    check({tag, " cc"}, cc, e.cc);
    r0 = result;
    c0 = cc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " held out_valid"}, out_valid, 1);
      check({tag, " held result"}, result, r0);
      check({tag, " held cc"}, cc, c0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check({tag, " back to idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  function automatic logic [19:0] model(input logic sub, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] f;
    logic [15:0] r;
    logic c, v;
    if (sub) begin
      r = x - y;
      c = x >= y;
      v = (x[15] != y[15]) && (r[15] != x[15]);
    end else begin
      f = {1'b0, x} + {1'b0, y};
      r = f[15:0];
      c = f[16];
      v = (x[15] == y[15]) && (r[15] != x[15]);
    end
    return {r, r[15], r == 16'h0, c, v};
  endfunction

  initial begin
    logic [19:0] m;
    logic [15:0] x, y;
    logic seen;
    @(negedge clk);
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset cc", cc, 0);
    rst = 0;
    cc_wr = 1; cc_wdata = 4'b0010;
    @(negedge clk);
    cc_wr = 0;
    check("cc_wr idle", cc, 4'b0010);
    issue("adc", 4'd2, 16'hFFFF, 16'h0000, 16'h0000, 4'b0110, 1, 0);
    issue("sub", 4'd3, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1, 0);
    issue("sbc", 4'd4, 16'h0005, 16'h0003, 16'h0002, 4'b0010, 1, 0);
    issue("ror1", 4'd11, 16'h0001, 16'h0001, 16'h8000, 4'b1010, 1, 0);
    issue("ror0", 4'd11, 16'h1234, 16'h0000, 16'h1234, 4'b0010, 1, 0);
    issue("lsl", 4'd8, 16'h0001, 16'h0011, 16'h0002, 4'b0010, 1, 0);
    issue("asr", 4'd10, 16'h8000, 16'h0004, 16'hF800, 4'b1010, 1, 0);
    issue("lsr", 4'd9, 16'h8000, 16'h000F, 16'h0001, 4'b0010, 1, 0);
    issue("mul", 4'd14, 16'd300, 16'd300, 16'h5F90, 4'b0010, 17, 3);
    issue("divu", 4'd15, 16'd1000, 16'd7, 16'd142, 4'b0010, 17, 0);
    issue("divu0", 4'd15, 16'd5, 16'd0, 16'hFFFF, 4'b1011, 2, 0);
    issue("mov", 4'd0, 16'd3, 16'd4, 16'd7, 4'b1011, 1, 0);
    cc_wr = 1; cc_wdata = 4'b1010;
    issue("and+cc_wr", 4'd5, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b1010, 1, 0);
    issue("xor", 4'd7, 16'h5555, 16'h5555, 16'h0000, 4'b0110, 1, 0);
    issue("mulz", 4'd14, 16'h8000, 16'h0002, 16'h0000, 4'b0110, 17, 0);
    issue("divu1", 4'd15, 16'hFFFF, 16'h0001, 16'hFFFF, 4'b1010, 17, 0);
    // carry-in must come from the flags before a same-cycle cc_wr
    cc_wr = 1; cc_wdata = 4'b0000;
    issue("adc+cc_wr", 4'd2, 16'h0001, 16'h0001, 16'h0003, 4'b0000, 1, 0);
    op = 4'd14; a = 16'd3; b = 16'd5; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 1);
    check("abort cc", cc, 0);
    check("abort result", result, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("aborted op discarded", seen, 0);
    issue("add ovf", 4'd1, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1, 0);
    mcc = cc;
    for (int i = 0; i < 6; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      m = model(i[0], x, y);
      issue(i[0] ? "rnd sub" : "rnd add", i[0] ? 4'd3 : 4'd1, x, y, m[19:4], m[3:0], 1, 0);
    end
    check("queue drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
